// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the bus controller slice.
//   DW / AW            data and address widths
//   DEF_NSLV           default number of slave regions
//   DEF_BASE/DEF_MASK  default address map (slave 0 in the LSBs)
//   state_t            controller FSM states
//   idx_width()        width of a slave index for a given slave count
package bus_pkg;

   localparam int unsigned DW       = 32;
   localparam int unsigned AW       = 32;
   localparam int unsigned DEF_NSLV = 4;

   localparam logic [DEF_NSLV*AW-1:0] DEF_BASE =
      {32'hFFFFFE00, 32'hC0000000, 32'hA0000000, 32'h00000000};
   localparam logic [DEF_NSLV*AW-1:0] DEF_MASK =
      {32'hFFFFFF00, 32'hE0000000, 32'hE0000000, 32'hF0000000};

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp,
      StErr
   } state_t;

   // A single slave still needs a 1-bit index signal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_addr_dec.sv
// bus_addr_dec: combinational priority address decoder.
//   m_addr  in   master address
//   hit     out  some region matches m_addr
//   idx     out  index of the lowest-numbered matching region (0 when no hit)
module bus_addr_dec
   import bus_pkg::*;
#(
   parameter int unsigned         NSLV = DEF_NSLV,
   parameter logic [NSLV*AW-1:0] BASE = DEF_BASE,
   parameter logic [NSLV*AW-1:0] MASK = DEF_MASK,
   localparam int unsigned        IW   = idx_width(NSLV)
) (
   input  logic [AW-1:0] m_addr,
   output logic          hit,
   output logic [IW-1:0] idx
);

   // Ascending scan; the first match is kept so overlapping regions resolve to the lowest index.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (!hit && ((m_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl: single-master to multi-slave bus controller with address decode and timeout.
//   clk, rst           clock, asynchronous active-high reset
//   m_addr, m_wdata    master address / write data
//   m_read, m_write    master request strobes, held until m_ready
//   m_rdata            read data, valid with m_ready
//   m_ready, m_err     one-cycle completion pulse and its error qualifier
//   s_sel              one-hot slave select (registered)
//   s_we, s_re         registered write / read enables
//   s_addr, s_wdata    registered address / write data
//   s_rdata, s_ack     concatenated slave read data, per-slave completion
module bus_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned         NSLV    = DEF_NSLV,
   parameter logic [NSLV*AW-1:0] BASE    = DEF_BASE,
   parameter logic [NSLV*AW-1:0] MASK    = DEF_MASK,
   parameter int unsigned         TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [AW-1:0]      m_addr,
   input  logic               m_read,
   input  logic               m_write,
   input  logic [DW-1:0]      m_wdata,
   output logic [DW-1:0]      m_rdata,
   output logic               m_ready,
   output logic               m_err,
   output logic [NSLV-1:0]    s_sel,
   output logic               s_we,
   output logic               s_re,
   output logic [AW-1:0]      s_addr,
   output logic [DW-1:0]      s_wdata,
   input  logic [NSLV*DW-1:0] s_rdata,
   input  logic [NSLV-1:0]    s_ack
);

   localparam int unsigned IW = idx_width(NSLV);
   // The counter never holds more than TIMEOUT-1.
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state_q;
   logic [IW-1:0]   idx_q;
   logic [CW-1:0]   cnt_q;

   logic            dec_hit;
   logic [IW-1:0]   dec_idx;
   logic [NSLV-1:0] dec_onehot;
   logic            sel_ack;
   logic [DW-1:0]   sel_rdata;
   logic            req;
   logic            bad_req;
   logic            tmo_hit;

   bus_addr_dec #(
      .NSLV (NSLV),
      .BASE (BASE),
      .MASK (MASK)
   ) u_dec (
      .m_addr (m_addr),
      .hit    (dec_hit),
      .idx    (dec_idx)
   );

   // One-hot of the decoded slave, and ack/rdata of the latched slave only.
   always_comb begin
      dec_onehot = '0;
      sel_ack    = 1'b0;
      sel_rdata  = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         dec_onehot[i] = (dec_idx == IW'(i));
         if (idx_q == IW'(i)) begin
            sel_ack   = s_ack[i];
            sel_rdata = s_rdata[i*DW +: DW];
         end
      end
   end

   assign req     = m_read | m_write;
   assign bad_req = (m_read & m_write) | ~dec_hit;
   assign tmo_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         m_rdata <= '0;
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         s_sel   <= '0;
         s_we    <= 1'b0;
         s_re    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  if (bad_req) begin
                     state_q <= StErr;
                     m_ready <= 1'b1;
                     m_err   <= 1'b1;
                     m_rdata <= '0;
                  end else begin
                     state_q <= StAccess;
                     idx_q   <= dec_idx;
                     cnt_q   <= '0;
                     s_sel   <= dec_onehot;
                     s_we    <= m_write;
                     s_re    <= m_read;
                     s_addr  <= m_addr;
                     s_wdata <= m_wdata;
                  end
               end
            end
            StAccess: begin
               // Ack is checked first so it wins over a coincident timeout.
               if (sel_ack) begin
                  state_q <= StResp;
                  m_ready <= 1'b1;
                  m_err   <= 1'b0;
                  m_rdata <= s_we ? '0 : sel_rdata;
                  s_sel   <= '0;
                  s_we    <= 1'b0;
                  s_re    <= 1'b0;
               end else if (tmo_hit) begin
                  state_q <= StErr;
                  m_ready <= 1'b1;
                  m_err   <= 1'b1;
                  m_rdata <= '0;
                  s_sel   <= '0;
                  s_we    <= 1'b0;
                  s_re    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StResp, StErr: begin
               state_q <= StIdle;
               m_ready <= 1'b0;
               m_err   <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: transaction-level model driving bus_ctrl with directed and random transfers.
module tb_bus_ctrl;

   localparam int NS  = 4;
   localparam int TMO = 255;

   localparam logic [31:0] BASE_TAB [NS] =
      '{32'h00000000, 32'hA0000000, 32'hC0000000, 32'hFFFFFE00};
   localparam logic [31:0] MASK_TAB [NS] =
      '{32'hF0000000, 32'hE0000000, 32'hE0000000, 32'hFFFFFF00};

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    m_addr;
   logic           m_read;
   logic           m_write;
   logic [31:0]    m_wdata;
   logic [31:0]    m_rdata;
   logic           m_ready;
   logic           m_err;
   logic [NS-1:0]  s_sel;
   logic           s_we;
   logic           s_re;
   logic [31:0]    s_addr;
   logic [31:0]    s_wdata;
   logic [NS*32-1:0] s_rdata;
   logic [NS-1:0]  s_ack;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected outputs for the current cycle, set by the driver.
   bit          chk_en = 1'b0;
   bit          chk_acc;
   bit          exp_ready;
   bit          exp_err;
   bit          exp_we;
   bit          exp_re;
   logic [3:0]  exp_sel;
   logic [31:0] exp_rdata;
   logic [31:0] exp_addr;
   logic [31:0] exp_wdata;

   bus_ctrl #(
      .NSLV    (NS),
      .TIMEOUT (TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_addr  (m_addr),
      .m_read  (m_read),
      .m_write (m_write),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .m_err   (m_err),
      .s_sel   (s_sel),
      .s_we    (s_we),
      .s_re    (s_re),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_rdata (s_rdata),
      .s_ack   (s_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // First region whose masked compare matches wins.
   function automatic void model_dec(input logic [31:0] a, output bit hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int i = 0; i < NS; i++) begin
         if ((a & MASK_TAB[i]) == BASE_TAB[i]) begin
            hit = 1'b1;
            idx = i;
            break;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ready", 32'(m_ready), 32'(exp_ready));
         chk("s_sel", 32'(s_sel), 32'(exp_sel));
         chk("s_we", 32'(s_we), 32'(exp_we));
         chk("s_re", 32'(s_re), 32'(exp_re));
         if (exp_ready) begin
            chk("m_err", 32'(m_err), 32'(exp_err));
            chk("m_rdata", m_rdata, exp_rdata);
         end
         if (chk_acc) begin
            chk("s_addr", s_addr, exp_addr);
            chk("s_wdata", s_wdata, exp_wdata);
         end
      end
   end

   // Cycle 0 presents the request; cycles 1..n are access cycles; cycle n+1 carries m_ready.
   // ack_at: access cycle in which the selected slave acks (0 or > TMO: never).
   task automatic xfer(input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [31:0] wdata, input int ack_at, input logic [31:0] rdat,
                       input logic [3:0] stray, output int rdy_at, output bit got_err,
                       output logic [31:0] got_rdata, output logic [3:0] sel1,
                       output int nsel);
      bit         hit;
      bit         acked;
      bit         acc;
      int         idx;
      int         n;
      logic [3:0] oh;
      model_dec(addr, hit, idx);
      oh = 4'(1 << idx);
      if (!hit || (rd && wr)) begin
         n     = 0;
         acked = 1'b0;
      end else if (ack_at >= 1 && ack_at <= TMO) begin
         n     = ack_at;
         acked = 1'b1;
      end else begin
         n     = TMO;
         acked = 1'b0;
      end
      rdy_at    = -1;
      got_err   = 1'b0;
      got_rdata = '0;
      sel1      = '0;
      nsel      = 0;
      for (int c = 0; c <= n + 1; c++) begin
         @(posedge clk);
         #1;
         acc = (c >= 1) && (c <= n);
         if (c <= n) begin
            m_addr  = addr;
            m_read  = rd;
            m_write = wr;
            m_wdata = wdata;
         end else begin
            m_read  = 1'b0;
            m_write = 1'b0;
            m_addr  = $urandom;
            m_wdata = $urandom;
         end
         for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
         if (acc) begin
            s_ack = (4'($urandom) | stray) & ~oh;
            if (acked && c == n) begin
               s_ack[idx]          = 1'b1;
               s_rdata[idx*32 +: 32] = rdat;
            end
         end else begin
            s_ack = 4'($urandom) | stray;
         end
         exp_ready = (c == n + 1);
         exp_err   = !acked;
         exp_rdata = (acked && rd) ? rdat : 32'h0;
         exp_sel   = acc ? oh : 4'h0;
         exp_we    = acc && wr;
         exp_re    = acc && rd;
         exp_addr  = addr;
         exp_wdata = wdata;
         chk_acc   = acc;
         @(negedge clk);
         if (c == 1) sel1 = s_sel;
         if (s_sel != '0) nsel++;
         if (m_ready && rdy_at < 0) begin
            rdy_at    = c;
            got_err   = m_err;
            got_rdata = m_rdata;
         end
      end
   endtask

   task automatic set_idle_exp();
      exp_ready = 1'b0;
      exp_sel   = '0;
      exp_we    = 1'b0;
      exp_re    = 1'b0;
      chk_acc   = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_m_ready"}, 32'(m_ready), 32'h0);
      chk({tag, "_m_err"}, 32'(m_err), 32'h0);
      chk({tag, "_m_rdata"}, m_rdata, 32'h0);
      chk({tag, "_s_sel"}, 32'(s_sel), 32'h0);
      chk({tag, "_s_we"}, 32'(s_we), 32'h0);
      chk({tag, "_s_re"}, 32'(s_re), 32'h0);
      chk({tag, "_s_addr"}, s_addr, 32'h0);
      chk({tag, "_s_wdata"}, s_wdata, 32'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_fail %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int          rdy;
      int          ns;
      int          nrdy;
      int          d_idx;
      bit          d_hit;
      bit          er;
      logic [31:0] rv;
      logic [3:0]  s1;

      rst     = 1'b1;
      m_addr  = '0;
      m_read  = 1'b0;
      m_write = 1'b0;
      m_wdata = '0;
      s_rdata = '0;
      s_ack   = '0;
      set_idle_exp();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Pin the decode model to the default map.
      model_dec(32'h00000040, d_hit, d_idx);
      chk("model_hit_40", 32'(d_hit), 32'h1);
      chk("model_idx_40", 32'(d_idx), 32'h0);
      model_dec(32'hA0000000, d_hit, d_idx);
      chk("model_idx_A0", 32'(d_idx), 32'h1);
      model_dec(32'hC0000004, d_hit, d_idx);
      chk("model_idx_C0", 32'(d_idx), 32'h2);
      model_dec(32'hFFFFFE10, d_hit, d_idx);
      chk("model_idx_FE10", 32'(d_idx), 32'h3);
      model_dec(32'h80000000, d_hit, d_idx);
      chk("model_hit_80", 32'(d_hit), 32'h0);

      // Write hit, ack in first access cycle.
      xfer(32'h00000040, 1'b0, 1'b1, 32'h12345678, 1, 32'h0, 4'h0, rdy, er, rv, s1, ns);
      chk("wr40_sel", 32'(s1), 32'h1);
      chk("wr40_latency", 32'(rdy), 32'd2);
      chk("wr40_err", 32'(er), 32'h0);

      // Read with ack in the third access cycle.
      xfer(32'hA0000000, 1'b1, 1'b0, 32'h0, 3, 32'h80000041, 4'h0, rdy, er, rv, s1, ns);
      chk("rdA0_rdata", rv, 32'h80000041);
      chk("rdA0_err", 32'(er), 32'h0);
      chk("rdA0_latency", 32'(rdy), 32'd4);

      // Unmapped address.
      xfer(32'h80000000, 1'b1, 1'b0, 32'h0, 1, 32'h0, 4'h0, rdy, er, rv, s1, ns);
      chk("rd80_latency", 32'(rdy), 32'd1);
      chk("rd80_err", 32'(er), 32'h1);
      chk("rd80_rdata", rv, 32'h0);
      chk("rd80_sel_cycles", 32'(ns), 32'd0);

      // Timeout, then ack exactly in the last allowed cycle.
      xfer(32'hFFFFFE10, 1'b0, 1'b1, 32'hCAFEF00D, 0, 32'h0, 4'h0, rdy, er, rv, s1, ns);
      chk("tmo_sel", 32'(s1), 32'h8);
      chk("tmo_sel_cycles", 32'(ns), 32'd255);
      chk("tmo_latency", 32'(rdy), 32'd256);
      chk("tmo_err", 32'(er), 32'h1);
      xfer(32'hFFFFFE10, 1'b0, 1'b1, 32'hCAFEF00D, 255, 32'h0, 4'h0, rdy, er, rv, s1, ns);
      chk("tmo_ack_latency", 32'(rdy), 32'd256);
      chk("tmo_ack_err", 32'(er), 32'h0);

      // Reset in the second access cycle of a read.
      chk_en = 1'b0;
      @(posedge clk);
      #1;
      m_addr  = 32'hC0000004;
      m_read  = 1'b1;
      m_write = 1'b0;
      s_ack   = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_pre_sel", 32'(s_sel), 32'h4);
      #1 rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      m_read = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      nrdy = 0;
      repeat (4) begin
         @(negedge clk);
         if (m_ready) nrdy++;
      end
      chk("rst_no_ready", 32'(nrdy), 32'h0);
      set_idle_exp();
      chk_en = 1'b1;
      xfer(32'hC0000004, 1'b1, 1'b0, 32'h0, 2, 32'hDEADBEEF, 4'h0, rdy, er, rv, s1, ns);
      chk("post_rst_rdata", rv, 32'hDEADBEEF);
      chk("post_rst_latency", 32'(rdy), 32'd3);

      // Read and write together.
      xfer(32'h00000000, 1'b1, 1'b1, 32'h0, 1, 32'h0, 4'h0, rdy, er, rv, s1, ns);
      chk("rdwr_latency", 32'(rdy), 32'd1);
      chk("rdwr_err", 32'(er), 32'h1);

      // Stray ack from slave 2 while slave 0 is selected.
      xfer(32'h00000100, 1'b1, 1'b0, 32'h0, 3, 32'h5A5A1234, 4'b0100, rdy, er, rv, s1, ns);
      chk("stray_latency", 32'(rdy), 32'd4);
      chk("stray_rdata", rv, 32'h5A5A1234);
      chk("stray_err", 32'(er), 32'h0);

      // Random traffic.
      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         bit          r;
         bit          w;
         int          ak;
         int          op;
         case ($urandom_range(0, 5))
            0:       a = $urandom & 32'h0FFFFFFF;
            1:       a = 32'hA0000000 | ($urandom & 32'h1FFFFFFF);
            2:       a = 32'hC0000000 | ($urandom & 32'h1FFFFFFF);
            3:       a = 32'hFFFFFE00 | ($urandom & 32'h000000FF);
            default: a = $urandom;
         endcase
         op = int'($urandom_range(0, 9));
         r  = (op <= 5);
         w  = (op == 0) || (op >= 6);
         ak = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
         xfer(a, r, w, $urandom, ak, $urandom, 4'($urandom_range(0, 15)),
              rdy, er, rv, s1, ns);
      end

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
